// File: rtl/core_control_fsm.sv
// core_control_fsm: fetch/decode/execute sequencer that decodes 16-bit instructions into datapath controls
module core_control_fsm (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] Instr_In,
    input  logic [4:0]  Flags_In,
    output logic [15:0] PC,
    output logic [3:0]  A_Mux_input,
    output logic [3:0]  B_Mux_input,
    output logic [3:0]  Reg_Enable,
    output logic        Imm_mux_input,
    output logic [15:0] Immediate,
    output logic [7:0]  OP,
    output logic        cin,
    output logic        Tri_Enable,
    output logic        Flags_Enable,
    output logic        Halted
);
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] w_pc_next;
    logic [3:0]  w_opcode;
    logic [3:0]  w_rdest;
    logic [3:0]  w_ext;
    logic [3:0]  w_rsrc;
    logic [15:0] w_sext;
    logic        w_rtype;
    logic        w_itype;
    logic        w_alu;
    logic        w_cmp;
    logic        w_branch;
    logic        w_halt;
    logic        w_cond;
    logic        w_c;
    logic        w_l;
    logic        w_f;
    logic        w_z;
    logic        w_n;

    assign w_opcode = r_ir[15:12];
    assign w_rdest  = r_ir[11:8];
    assign w_ext    = r_ir[7:4];
    assign w_rsrc   = r_ir[3:0];
    assign w_sext   = {{8{r_ir[7]}}, r_ir[7:0]};

    assign w_rtype  = w_opcode == 4'h0;
    assign w_itype  = w_opcode >= 4'h1 && w_opcode <= 4'hB;
    assign w_alu    = w_rtype || w_itype;
    assign w_cmp    = (w_rtype && w_ext == 4'hB) || w_opcode == 4'hB;
    assign w_branch = w_opcode == 4'hC;
    assign w_halt   = w_opcode == 4'hF;

    assign {w_c, w_l, w_f, w_z, w_n} = Flags_In;

    assign PC            = r_pc;
    assign A_Mux_input   = w_rdest;
    assign B_Mux_input   = w_rsrc;
    assign Reg_Enable    = w_rdest;
    assign Immediate     = w_sext;
    assign Imm_mux_input = w_itype;
    assign OP            = w_rtype ? {4'h0, w_ext} : w_itype ? {w_opcode, 4'h0} : 8'h00;
    assign cin           = (w_rtype && w_ext == 4'h7) ? w_c : 1'b0;

    // Branch condition selected by the Rdest field, evaluated against the live flags
    always_comb begin
        w_cond = 1'b0;
        case (w_rdest)
            4'h0:    w_cond = w_z;
            4'h1:    w_cond = !w_z;
            4'h2:    w_cond = w_c;
            4'h3:    w_cond = !w_c;
            4'h4:    w_cond = w_l;
            4'h5:    w_cond = !w_l;
            4'h6:    w_cond = w_n;
            4'h7:    w_cond = !w_n;
            4'h8:    w_cond = w_f;
            4'h9:    w_cond = !w_f;
            4'hE:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // State, PC and instruction register; reset drops straight back to FETCH at address 0 with a NOP in IR
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
            r_pc    <= 16'h0000;
            r_ir    <= 16'hE000;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (r_state == S_DECODE)
                r_ir <= Instr_In;
        end
    end

    // Next state, next PC and the state-qualified enables
    always_comb begin
        w_next       = r_state;
        w_pc_next    = r_pc;
        Tri_Enable   = 1'b0;
        Flags_Enable = 1'b0;
        Halted       = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXECUTE;
            S_EXECUTE: begin
                Tri_Enable   = w_alu && !w_cmp;
                Flags_Enable = w_alu;
                w_next       = w_halt ? S_HALT : S_FETCH;
                w_pc_next    = w_halt ? r_pc : (w_branch && w_cond) ? r_pc + w_sext : r_pc + 16'd1;
            end
            S_HALT:   Halted = 1'b1;
            default:  w_next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_core_control_fsm.sv
// tb_core_control_fsm: scoreboard bench driving directed programs through a synchronous instruction memory
module tb_core_control_fsm;
    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  re;
        logic        imux;
        logic [15:0] imm;
        logic [7:0]  op;
        logic        cin;
        logic        tri_e;
        logic        fl_e;
        logic        halted;
    } obs_t;

    typedef struct {
        int    cyc;
        string nm;
        obs_t  v;
        obs_t  m;
    } exp_t;

    logic        clk;
    logic        Reset;
    logic [15:0] Instr_In;
    logic [4:0]  Flags_In;
    logic [15:0] PC;
    logic [3:0]  A_Mux_input;
    logic [3:0]  B_Mux_input;
    logic [3:0]  Reg_Enable;
    logic        Imm_mux_input;
    logic [15:0] Immediate;
    logic [7:0]  OP;
    logic        cin;
    logic        Tri_Enable;
    logic        Flags_Enable;
    logic        Halted;

    logic [15:0] mem [0:65535];
    exp_t        q[$];
    int          cyc;
    int          checks;
    int          errors;
    obs_t        act;

    core_control_fsm dut (
        .clk(clk), .Reset(Reset), .Instr_In(Instr_In), .Flags_In(Flags_In), .PC(PC),
        .A_Mux_input(A_Mux_input), .B_Mux_input(B_Mux_input), .Reg_Enable(Reg_Enable),
        .Imm_mux_input(Imm_mux_input), .Immediate(Immediate), .OP(OP), .cin(cin),
        .Tri_Enable(Tri_Enable), .Flags_Enable(Flags_Enable), .Halted(Halted)
    );

    assign act = {PC, A_Mux_input, B_Mux_input, Reg_Enable, Imm_mux_input, Immediate, OP, cin, Tri_Enable, Flags_Enable, Halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears one cycle after the address
    always @(posedge clk) Instr_In <= mem[PC];

    // Cycles since reset release; EXECUTE of the n-th instruction is sampled at cyc = 3n+2
    always @(posedge clk or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic obs_t ob(logic [15:0] pc, logic [3:0] a, logic [3:0] b, logic [3:0] re, logic imux,
                                logic [15:0] imm, logic [7:0] op, logic c, logic t, logic f, logic h);
        return {pc, a, b, re, imux, imm, op, c, t, f, h};
    endfunction

    function automatic obs_t m_ctl();
        obs_t m = '0;
        m.pc = '1;
        m.tri_e = 1'b1;
        m.fl_e = 1'b1;
        m.halted = 1'b1;
        return m;
    endfunction

    function automatic obs_t m_all();
        obs_t m = '1;
        return m;
    endfunction

    function automatic obs_t m_nop();
        obs_t m = '1;
        m.op = '0;
        m.imux = 1'b0;
        return m;
    endfunction

    function automatic void chk(string nm, obs_t a, obs_t e, obs_t m);
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, a & m, e & m, m);
        end
    endfunction

    function automatic void push(int c, string nm, obs_t v, obs_t m);
        exp_t e;
        e.cyc = c;
        e.nm = nm;
        e.v = v;
        e.m = m;
        q.push_back(e);
    endfunction

    // Monitor: pops every expectation due at this cycle and compares it with the DUT outputs
    always @(negedge clk) begin
        exp_t e;
        if (Reset) begin
            while (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: missed at cycle %0d, due %0d", e.nm, cyc, e.cyc);
                end else chk(e.nm, act, e.v, e.m);
            end
        end
    end

    task automatic fill_nop();
        for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 Reset = 1'b1;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d pending got %0d expected 0", nm, q.size(), q.size());
            q.delete();
        end
    endtask

    initial begin
        obs_t t;
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        Flags_In = 5'b00000;
        fill_nop();
        #2 Reset = 1'b0;
        #1 chk("async_reset", act, ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), m_all());

        mem[0] = 16'h0352;
        mem[1] = 16'h54FE;
        mem[2] = 16'h0AB1;
        mem[3] = 16'h0172;
        mem[4] = 16'hD000;
        mem[5] = 16'hF000;
        mem[6] = 16'h0352;
        Flags_In = 5'b10000;
        push(1, "decode0", ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(2, "rtype_exec", ob(16'h0000, 4'h3, 4'h2, 4'h3, 1'b0, 16'h0052, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0), m_all());
        push(3, "pc_after_rtype", ob(16'h0001, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(5, "itype_exec", ob(16'h0001, 4'h4, 4'hE, 4'h4, 1'b1, 16'hFFFE, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0), m_all());
        push(8, "cmp_exec", ob(16'h0002, 4'hA, 4'h1, 4'hA, 1'b0, 16'hFFB1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0), m_all());
        push(11, "addc_exec", ob(16'h0003, 4'h1, 4'h2, 4'h1, 1'b0, 16'h0072, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0), m_all());
        push(14, "reserved_exec", ob(16'h0004, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), m_nop());
        push(17, "halt_exec", ob(16'h0005, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), m_nop());
        for (int i = 18; i < 28; i++)
            push(i, "halted", ob(16'h0005, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1), m_ctl());
        release_reset();
        drain("prog1");
        #1 Reset = 1'b0;
        #1 chk("reset_mid_halt", act, ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());

        fill_nop();
        mem[0] = 16'hCE10;
        mem[16'h0010] = 16'hC0FC;
        Flags_In = 5'b00010;
        push(2, "uc_branch_exec", ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(3, "uc_branch_pc", ob(16'h0010, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(5, "beq_exec", ob(16'h0010, 4'h0, 4'hC, 4'h0, 1'b0, 16'hFFFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), m_nop());
        push(6, "beq_taken_pc", ob(16'h000C, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        release_reset();
        drain("branch_taken");
        #1 Reset = 1'b0;

        mem[16'h0011] = 16'hCA05;
        mem[16'h0012] = 16'hC1F0;
        Flags_In = 5'b00000;
        push(6, "beq_not_taken_pc", ob(16'h0011, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(9, "never_code_pc", ob(16'h0012, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(11, "bne_exec", ob(16'h0012, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(12, "bne_taken_back_pc", ob(16'h0002, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        release_reset();
        drain("branch_not_taken");
        #1 Reset = 1'b0;

        fill_nop();
        mem[0] = 16'hCEFF;
        push(3, "jump_to_ffff", ob(16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        push(5, "nop_exec_ffff", ob(16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), m_nop());
        push(6, "pc_wrap", ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        release_reset();
        drain("wrap");
        #1 Reset = 1'b0;

        mem[0] = 16'h0352;
        release_reset();
        @(negedge clk);
        @(negedge clk);
        t = '0;
        t.tri_e = 1'b1;
        t.fl_e = 1'b1;
        #1 chk("exec_before_reset", act, ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0), t);
        Reset = 1'b0;
        #1 chk("reset_mid_exec", act, ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());
        @(posedge clk);
        #1 chk("held_in_reset", act, ob(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0), m_ctl());

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
